// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter sharing one SR latch between two requesters.
// Drives timed, mutually exclusive s/r pulses, waits a settle gap, then checks q.
module sr_latch_arbiter #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_a_valid,
  input  logic req_a_op,
  output logic req_a_ready,
  input  logic req_b_valid,
  input  logic req_b_op,
  output logic req_b_ready,
  output logic s,
  output logic r,
  input  logic q,
  output logic done,
  output logic done_id,
  output logic err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             op_r, op_next_s;
  logic             owner_r, owner_next_s;
  logic             rr_ptr_r, rr_ptr_next_s;
  logic             s_r, s_next_s;
  logic             r_r, r_next_s;
  logic             done_r, done_next_s;
  logic             done_id_r, done_id_next_s;
  logic             err_r, err_next_s;
  logic             grant_a_s, grant_b_s;
  logic             acc_op_s;

  // Grant selection: only in IDLE, rr_ptr breaks ties (0=A, 1=B)
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req_a_valid && (!req_b_valid || !rr_ptr_r)) begin
        grant_a_s = 1'b1;
      end else if (req_b_valid) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign req_a_ready = grant_a_s;
  assign req_b_ready = grant_b_s;
  assign acc_op_s    = grant_b_s ? req_b_op : req_a_op;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    op_next_s      = op_r;
    owner_next_s   = owner_r;
    rr_ptr_next_s  = rr_ptr_r;
    s_next_s       = 1'b0;
    r_next_s       = 1'b0;
    done_next_s    = 1'b0;
    done_id_next_s = done_id_r;
    err_next_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_a_s || grant_b_s) begin
          op_next_s     = acc_op_s;
          owner_next_s  = grant_b_s;
          rr_ptr_next_s = grant_a_s;
          state_next_s  = ST_PULSE;
          cnt_next_s    = PULSE_LOAD;
          s_next_s      = acc_op_s;
          r_next_s      = ~acc_op_s;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = ST_GAP;
          cnt_next_s   = GAP_LOAD;
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
          s_next_s   = op_r;
          r_next_s   = ~op_r;
        end
      end
      ST_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = ST_CHECK;
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end
      ST_CHECK: begin
        // Result lands in the first IDLE cycle so a new grant can overlap it
        done_next_s    = 1'b1;
        done_id_next_s = owner_r;
        err_next_s     = (q != op_r);
        state_next_s   = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous reset that aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      op_r      <= 1'b0;
      owner_r   <= 1'b0;
      rr_ptr_r  <= 1'b0;
      s_r       <= 1'b0;
      r_r       <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      op_r      <= op_next_s;
      owner_r   <= owner_next_s;
      rr_ptr_r  <= rr_ptr_next_s;
      s_r       <= s_next_s;
      r_r       <= r_next_s;
      done_r    <= done_next_s;
      done_id_r <= done_id_next_s;
      err_r     <= err_next_s;
    end
  end

  assign s       = s_r;
  assign r       = r_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign err     = err_r;

endmodule

// File: doc/sr_latch_arbiter.md
Name: sr_latch_arbiter

Overview:
- Shares one SR latch between two requesters, A and B.
- Each requester issues set or clear commands through a valid/ready handshake.
- The block arbitrates round-robin, drives timed, mutually exclusive s/r pulses, then waits a settle gap.
- It samples the latch q output to confirm the operation and reports done/err.
- Sits between control logic and an SR_latch instance (s, r in; q out).

Parameters:
- PULSE_W, 2, cycles s or r is held high per operation (legal range 1..2^CNT_W-1)
- GAP_W, 1, settle cycles with s=r=0 before q is checked (legal range 1..2^CNT_W-1)
- CNT_W, 4, width of the internal cycle counter

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req_a_valid  input  1  requester A has a command
- req_a_op  input  1  A's command: 1=set, 0=clear
- req_a_ready  output  1  A's command accepted this cycle when valid&&ready
- req_b_valid  input  1  requester B has a command
- req_b_op  input  1  B's command: 1=set, 0=clear
- req_b_ready  output  1  B's command accepted this cycle when valid&&ready
- s  output  1  latch set drive, registered
- r  output  1  latch reset drive, registered
- q  input  1  latch output feedback
- done  output  1  one-cycle pulse when an operation completes
- done_id  output  1  owner of the completed op: 0=A, 1=B; valid with done
- err  output  1  one-cycle pulse with done when q != op at check

Behaviour:
- Reset (synchronous, active-high): state=IDLE; s=r=0; done=err=done_id=0; counter=0; rr_ptr=0 (A preferred).
  - Reset mid-operation aborts immediately: s=r=0 after the edge, and no done is issued.
- States: IDLE, PULSE, GAP, CHECK.
- IDLE:
  - ready is combinational and asserted only in IDLE, for at most one requester (the grantee).
  - Only A valid → grant A. Only B valid → grant B.
  - Both valid → grant the side selected by rr_ptr (0=A, 1=B).
  - On acceptance, latch op and owner and set rr_ptr to the other side.
  - rr_ptr changes only on acceptance.
  - Next state is PULSE and counter loads PULSE_W-1.
- PULSE:
  - s=op, r=~op, so exactly one is high; s and r are never both 1 in any cycle.
  - Lasts exactly PULSE_W cycles, then goes to GAP with counter loaded GAP_W-1.
- GAP: s=r=0 for exactly GAP_W cycles, then goes to CHECK.
- CHECK (1 cycle):
  - Compare q against the latched op.
  - Next cycle: done=1, done_id=owner, err=(q!=op); return to IDLE.
  - done/err/done_id are registered, so they pulse in the first IDLE cycle.
  - A new request may be accepted in that same cycle.
- Latency (acceptance edge at T):
  - s/r high for cycles T+1..T+PULSE_W.
  - Gap for cycles T+PULSE_W+1..T+PULSE_W+GAP_W.
  - CHECK at T+PULSE_W+GAP_W+1; done at T+PULSE_W+GAP_W+2.
  - Default parameters: done 5 cycles after acceptance.
- Busy handling: both readys are 0 outside IDLE. A valid requester must hold valid and op stable until accepted. Op changes while not ready are ignored.
- The latched op is immune to input changes after acceptance.
- A set while q is already 1 (or a clear while q is already 0) still executes the full sequence and completes with err=0.

Test Plan:
- Reset then A set: reset 1 for 2 cycles; A valid, op=1 → ready_a=1 same cycle; s=1 for 2 cycles, r=0 throughout; gap 1 cycle; done=1, done_id=0, err=0 5 cycles after acceptance; q=1.
- B clear after the latch is set: B valid, op=0 → r=1 for 2 cycles, s=0 throughout; done, done_id=1, err=0; q=0.
- Simultaneous A set and B clear, held valid: grants in order A, B, then A again on the next pair (rr_ptr alternates). Check s and r are never both 1 in any cycle and total 10 cycles per pair.
- Request during busy: B valid raised while A is in PULSE → ready_b=0 until IDLE. B is accepted in the cycle done(A) pulses, with no idle bubble.
- Fault: tie q to 0 and issue A set → done with err=1, done_id=0.
- Reset mid-PULSE: assert reset while s=1 → s=0 next edge, no done, ready_a resumes after reset release; rr_ptr=0.
